adder_tree_accum: RTL and testbench

ADDER_TREE_ACCUM -- requirements
Module: adder_tree_accum

---
 rtl/adder_tree_accum.sv | 109 ++++++++++
 tb/tb_adder_tree_accum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_accum
//  Description : Block accumulator for adder-tree result beats. Sums a
//                programmable number of unsigned beats per block and holds
//                the total (with its beat count) until downstream accepts it.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_tree_accum #(
    parameter int IN_WIDTH  = 49,
    parameter int LEN_WIDTH = 8,
    parameter int ACC_WIDTH = IN_WIDTH + LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_sum,
    input  logic [LEN_WIDTH-1:0] blk_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [LEN_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_len_one = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] r_len;

    logic                 w_accept;
    logic [LEN_WIDTH-1:0] w_len_eff;
    logic [LEN_WIDTH-1:0] w_cnt_inc;
    logic [ACC_WIDTH-1:0] w_sum_ext;

    // Handshake decode and helper arithmetic
    always_comb begin
        in_ready  = (r_state != S_HOLD);
        out_valid = (r_state == S_HOLD);
        out_acc   = r_acc;
        out_count = r_cnt;
        w_accept  = in_valid & in_ready;
        // A zero length field still describes a one-beat block
        w_len_eff = (blk_len == '0) ? c_len_one : blk_len;
        w_cnt_inc = r_cnt + c_len_one;
        w_sum_ext = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, in_sum};
    end

    // Block sequencing: collect beats, then hold the result until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_len_eff == c_len_one) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && (w_cnt_inc == r_len)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset discards any partial or held block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, beat counter and the block length latched on the first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_acc <= w_sum_ext;
                r_cnt <= c_len_one;
                r_len <= w_len_eff;
            end else begin
                r_acc <= r_acc + w_sum_ext;
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_tree_accum
//  Description : Self-checking bench for adder_tree_accum: directed block
//                scenarios plus randomized blocks scored against plain sums.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_tree_accum;

    localparam int IW = 49;
    localparam int LW = 8;
    localparam int AW = IW + LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_sum;
    logic [LW-1:0] blk_len;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic [LW-1:0] out_count;

    int n_chk = 0;
    int n_err = 0;

    adder_tree_accum #(
        .IN_WIDTH  (IW),
        .LEN_WIDTH (LW),
        .ACC_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .blk_len   (blk_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=stalled expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [IW-1:0] rand49();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[IW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) until it has been accepted
    task automatic send_beat(input logic [IW-1:0] s, input logic [LW-1:0] l);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_sum   = s;
        blk_len  = l;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk("beat_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_sum   = rand49();
        blk_len  = LW'($urandom);
    endtask

    // Idle cycles with junk on the data inputs; block must keep collecting
    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            in_valid = 1'b0;
            in_sum   = rand49();
            blk_len  = LW'($urandom);
            tick();
            chk("gap_no_valid", 64'(out_valid), 64'd0);
        end
    endtask

    // Check the held result, stall for 'hold' cycles with a beat offered, then take it
    task automatic get_result(input string tag, input logic [63:0] ea, input logic [63:0] ec,
                              input int hold);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_acc"},   64'(out_acc),   ea);
        chk({tag, "_count"}, 64'(out_count), ec);
        chk({tag, "_busy"},  64'(in_ready),  64'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_sum    = rand49();
            blk_len   = LW'($urandom);
            tick();
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_acc"},   64'(out_acc),   ea);
            chk({tag, "_hold_count"}, 64'(out_count), ec);
            chk({tag, "_hold_busy"},  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_drop"},  64'(out_valid), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    // Directed scenarios followed by randomized blocks
    initial begin
        logic [63:0] exp_acc;
        logic [IW-1:0] beat;
        int len;
        int eff;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        blk_len   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_acc",   64'(out_acc),   64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);

        // Four back-to-back beats, downstream always ready
        out_ready = 1'b1;
        send_beat(49'd10, 8'd4);
        send_beat(49'd20, 8'd4);
        send_beat(49'd30, 8'd4);
        chk("b4_not_done", 64'(out_valid), 64'd0);
        send_beat(49'd40, 8'd4);
        get_result("b4", 64'd100, 64'd4, 0);

        // Zero length means a one-beat block
        send_beat(49'd7, 8'd0);
        get_result("len0", 64'd7, 64'd1, 2);

        // Longest block of all-ones beats: no wrap
        for (int k = 0; k < 255; k++) begin
            send_beat({IW{1'b1}}, 8'd255);
        end
        get_result("max", 64'd255 * ((64'd1 << IW) - 64'd1), 64'd255, 1);

        // Gapped beats and a five-cycle downstream stall
        send_beat(49'd5, 8'd3);
        gap(1);
        send_beat(49'd6, 8'd3);
        gap(2);
        send_beat(49'd9, 8'd3);
        get_result("gaps", 64'd20, 64'd3, 5);

        // Reset in the middle of a block, with a beat offered on the reset edge
        send_beat(49'd100, 8'd4);
        send_beat(49'd200, 8'd4);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sum   = 49'd300;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc",   64'(out_acc),   64'd0);
        chk("mid_rst_count", 64'(out_count), 64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        gap(2);
        send_beat(49'd1, 8'd2);
        send_beat(49'd2, 8'd2);
        get_result("post_rst", 64'd3, 64'd2, 0);

        // Length changes after the first beat are ignored
        send_beat(49'd11, 8'd2);
        send_beat(49'd12, 8'd9);
        get_result("len_latch", 64'd23, 64'd2, 0);

        // Randomized blocks against a plain running sum
        for (int b = 0; b < 25; b++) begin
            len     = $urandom_range(0, 12);
            eff     = (len == 0) ? 1 : len;
            exp_acc = 64'd0;
            for (int k = 0; k < eff; k++) begin
                gap($urandom_range(0, 2));
                beat    = rand49();
                exp_acc = exp_acc + 64'(beat);
                send_beat(beat, (k == 0) ? LW'(len) : LW'($urandom));
                if (k < eff - 1) begin
                    chk("rnd_not_done", 64'(out_valid), 64'd0);
                end
            end
            get_result("rnd", exp_acc, 64'(eff), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
